// File: rtl/int_seq.sv
// Interrupt/reset sequencer ahead of the opcode latch: arbitrates RST/NMI/IRQ at
// instruction boundaries and forces BRK. Define INT_SEQ_SYNC_EN to synchronize irq_b/nmi_b.
module int_seq #(
    parameter int          RESET_CYCLES = 6,
    parameter logic [15:0] RST_VEC      = 16'hFFFC,
    parameter logic [15:0] NMI_VEC      = 16'hFFFA,
    parameter logic [15:0] IRQ_VEC      = 16'hFFFE
) (
    input  logic        ph2,
    input  logic        reset,
    input  logic        irq_b,
    input  logic        nmi_b,
    input  logic        i_flag,
    input  logic        last_cycle,
    input  logic        int_ack,
    input  logic [7:0]  data_in,
    output logic [7:0]  opcode_out,
    output logic        inject,
    output logic [15:0] vec_addr,
    output logic        b_flag,
    output logic        busy
);

    localparam logic [2:0] S_RST_HOLD = 3'd0;
    localparam logic [2:0] S_RST_REQ  = 3'd1;
    localparam logic [2:0] S_IDLE     = 3'd2;
    localparam logic [2:0] S_INJECT   = 3'd3;
    localparam logic [2:0] S_SERVICE  = 3'd4;

    localparam logic [1:0] SRC_RST = 2'd0;
    localparam logic [1:0] SRC_NMI = 2'd1;
    localparam logic [1:0] SRC_IRQ = 2'd2;

    localparam logic [3:0] HOLD_LAST = 4'(RESET_CYCLES - 1);

    logic       irq_s;
    logic       nmi_s;

`ifdef INT_SEQ_SYNC_EN
    logic [1:0] irq_sync_q;
    logic [1:0] nmi_sync_q;

    always_ff @(posedge ph2 or posedge reset) begin
        if (reset) begin
            irq_sync_q <= 2'b11;
            nmi_sync_q <= 2'b11;
        end else begin
            irq_sync_q <= {irq_sync_q[0], irq_b};
            nmi_sync_q <= {nmi_sync_q[0], nmi_b};
        end
    end

    assign irq_s = irq_sync_q[1];
    assign nmi_s = nmi_sync_q[1];
`else
    assign irq_s = irq_b;
    assign nmi_s = nmi_b;
`endif

    logic [2:0] state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [1:0] src_q, src_d;
    logic       nmi_prev_q;
    logic       nmi_pend_q, nmi_pend_d;
    logic       nmi_edge;
    logic       nmi_clr;

    assign nmi_edge = nmi_prev_q & ~nmi_s;
    assign nmi_clr  = (state_q == S_SERVICE) & int_ack & (src_q == SRC_NMI);

    // A fresh edge outranks the acknowledge clear so it is never dropped
    always_comb begin
        nmi_pend_d = nmi_pend_q;
        if (nmi_clr)
            nmi_pend_d = 1'b0;
        if (nmi_edge)
            nmi_pend_d = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        src_d   = src_q;
        unique case (state_q)
            S_RST_HOLD: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == HOLD_LAST)
                    state_d = S_RST_REQ;
            end
            S_RST_REQ: begin
                if (last_cycle) begin
                    state_d = S_INJECT;
                    src_d   = SRC_RST;
                end
            end
            S_IDLE: begin
                if (last_cycle && nmi_pend_q) begin
                    state_d = S_INJECT;
                    src_d   = SRC_NMI;
                end else if (last_cycle && !irq_s && !i_flag) begin
                    state_d = S_INJECT;
                    src_d   = SRC_IRQ;
                end
            end
            S_INJECT: state_d = S_SERVICE;
            S_SERVICE: begin
                if (int_ack)
                    state_d = S_IDLE;
            end
            default: state_d = S_RST_HOLD;
        endcase
    end

    always_ff @(posedge ph2 or posedge reset) begin
        if (reset) begin
            state_q    <= S_RST_HOLD;
            cnt_q      <= 4'd0;
            src_q      <= SRC_RST;
            nmi_prev_q <= 1'b1;
            nmi_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            src_q      <= src_d;
            nmi_prev_q <= nmi_s;
            nmi_pend_q <= nmi_pend_d;
        end
    end

    // IDLE presents the BRK vector so software BRK needs no sequencer help
    always_comb begin
        vec_addr = IRQ_VEC;
        b_flag   = 1'b1;
        if (state_q != S_IDLE) begin
            unique case (src_q)
                SRC_NMI: begin
                    vec_addr = NMI_VEC;
                    b_flag   = 1'b0;
                end
                SRC_IRQ: begin
                    vec_addr = IRQ_VEC;
                    b_flag   = 1'b0;
                end
                default: begin
                    vec_addr = RST_VEC;
                    b_flag   = 1'b1;
                end
            endcase
        end
    end

    assign inject     = (state_q == S_INJECT);
    assign opcode_out = inject ? 8'h00 : data_in;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_int_seq.sv
// Scoreboard bench for int_seq: expected vectors queued at each boundary
// that should inject, compared when the DUT raises inject.
module tb_int_seq;

`ifdef INT_SEQ_SYNC_EN
    localparam int SL = 2;
`else
    localparam int SL = 0;
`endif

    logic        ph2 = 1'b0;
    logic        reset = 1'b1;
    logic        irq_b = 1'b1;
    logic        nmi_b = 1'b1;
    logic        i_flag = 1'b1;
    logic        last_cycle = 1'b0;
    logic        int_ack = 1'b0;
    logic [7:0]  data_in = 8'hEA;
    logic [7:0]  opcode_out;
    logic        inject;
    logic [15:0] vec_addr;
    logic        b_flag;
    logic        busy;

    typedef struct packed {
        logic [15:0] vec;
        logic        b;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    int_seq dut (
        .ph2(ph2), .reset(reset), .irq_b(irq_b), .nmi_b(nmi_b),
        .i_flag(i_flag), .last_cycle(last_cycle), .int_ack(int_ack),
        .data_in(data_in), .opcode_out(opcode_out), .inject(inject),
        .vec_addr(vec_addr), .b_flag(b_flag), .busy(busy)
    );

    always #5 ph2 = ~ph2;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge ph2);
        #1;
    endtask

    always @(negedge ph2) begin
        if (!reset && inject === 1'b1) begin
            if (sb.size() == 0) begin
                chk("inj_unexpected", 16'd1, 16'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("inj_vec", vec_addr, e.vec);
                chk("inj_bflag", {15'd0, b_flag}, {15'd0, e.b});
                chk("inj_opcode", {8'd0, opcode_out}, 16'h0000);
            end
        end
    end

    initial begin
        exp_t e;
        // reset values
        repeat (2) tick;
        chk("rst_busy", {15'd0, busy}, 16'd1);
        chk("rst_inject", {15'd0, inject}, 16'd0);
        chk("rst_vec", vec_addr, 16'hFFFC);
        chk("rst_bflag", {15'd0, b_flag}, 16'd1);
        chk("rst_opcode", {8'd0, opcode_out}, 16'h00EA);
        reset = 1'b0;
        repeat (4) begin
            tick;
            chk("hold_busy", {15'd0, busy}, 16'd1);
        end
        last_cycle = 1'b1;
        tick;
        chk("hold_no_inj5", {15'd0, inject}, 16'd0);
        tick;
        chk("hold_no_inj6", {15'd0, inject}, 16'd0);
        chk("req_busy", {15'd0, busy}, 16'd1);
        e.vec = 16'hFFFC; e.b = 1'b1; sb.push_back(e);
        tick;
        chk("rst_inj", {15'd0, inject}, 16'd1);
        last_cycle = 1'b0;
        tick;
        chk("rst_svc_inj", {15'd0, inject}, 16'd0);
        chk("rst_svc_vec", vec_addr, 16'hFFFC);
        chk("rst_svc_busy", {15'd0, busy}, 16'd1);
        int_ack = 1'b1;
        tick;
        int_ack = 1'b0;
        chk("idle_busy", {15'd0, busy}, 16'd0);
        chk("idle_vec", vec_addr, 16'hFFFE);
        chk("idle_bflag", {15'd0, b_flag}, 16'd1);

        // IRQ masked by i_flag
        data_in = 8'hA9;
        irq_b = 1'b0;
        i_flag = 1'b1;
        repeat (SL) tick;
        last_cycle = 1'b1;
        tick;
        chk("mask_inj", {15'd0, inject}, 16'd0);
        chk("mask_busy", {15'd0, busy}, 16'd0);
        chk("mask_opcode", {8'd0, opcode_out}, 16'h00A9);

        // IRQ taken
        i_flag = 1'b0;
        e.vec = 16'hFFFE; e.b = 1'b0; sb.push_back(e);
        tick;
        chk("irq_inj", {15'd0, inject}, 16'd1);
        last_cycle = 1'b0;
        irq_b = 1'b1;
        tick;
        chk("irq_svc_vec", vec_addr, 16'hFFFE);
        chk("irq_svc_bflag", {15'd0, b_flag}, 16'd0);
        chk("irq_svc_opcode", {8'd0, opcode_out}, 16'h00A9);
        i_flag = 1'b1;
        last_cycle = 1'b1;
        tick;
        chk("irq_svc_hold", vec_addr, 16'hFFFE);
        chk("irq_svc_busy", {15'd0, busy}, 16'd1);
        last_cycle = 1'b0;
        int_ack = 1'b1;
        tick;
        chk("irq_done", {15'd0, busy}, 16'd0);
        tick;
        int_ack = 1'b0;
        chk("ack_idle_ign", {15'd0, busy}, 16'd0);
        repeat (SL) tick;

        // NMI edge, boundary three cycles later
        nmi_b = 1'b0;
        repeat (SL + 1) tick;
        chk("nmi_pend_set", {15'd0, dut.nmi_pend_q}, 16'd1);
        repeat (2) tick;
        chk("nmi_wait", {15'd0, busy}, 16'd0);
        last_cycle = 1'b1;
        e.vec = 16'hFFFA; e.b = 1'b0; sb.push_back(e);
        tick;
        last_cycle = 1'b0;
        nmi_b = 1'b1;
        tick;
        chk("nmi_svc_vec", vec_addr, 16'hFFFA);
        int_ack = 1'b1;
        tick;
        int_ack = 1'b0;
        chk("nmi_pend_clr", {15'd0, dut.nmi_pend_q}, 16'd0);
        repeat (SL) tick;

        // NMI and IRQ on the same boundary
        nmi_b = 1'b0;
        irq_b = 1'b0;
        i_flag = 1'b0;
        repeat (SL + 1) tick;
        last_cycle = 1'b1;
        e.vec = 16'hFFFA; e.b = 1'b0; sb.push_back(e);
        tick;
        last_cycle = 1'b0;
        nmi_b = 1'b1;
        tick;
        chk("both_nmi_first", vec_addr, 16'hFFFA);
        int_ack = 1'b1;
        tick;
        int_ack = 1'b0;
        last_cycle = 1'b1;
        e.vec = 16'hFFFE; e.b = 1'b0; sb.push_back(e);
        tick;
        chk("both_irq_next", {15'd0, inject}, 16'd1);
        last_cycle = 1'b0;
        irq_b = 1'b1;
        i_flag = 1'b1;
        tick;
        int_ack = 1'b1;
        tick;
        int_ack = 1'b0;
        repeat (SL) tick;

        // second NMI edge coinciding with the ack
        nmi_b = 1'b0;
        repeat (SL + 1) tick;
        last_cycle = 1'b1;
        e.vec = 16'hFFFA; e.b = 1'b0; sb.push_back(e);
        tick;
        last_cycle = 1'b0;
        nmi_b = 1'b1;
        repeat (SL + 1) tick;
        nmi_b = 1'b0;
        repeat (SL) tick;
        int_ack = 1'b1;
        tick;
        int_ack = 1'b0;
        chk("nmi_coinc_idle", {15'd0, busy}, 16'd0);
        chk("nmi_coinc_pend", {15'd0, dut.nmi_pend_q}, 16'd1);
        last_cycle = 1'b1;
        e.vec = 16'hFFFA; e.b = 1'b0; sb.push_back(e);
        tick;
        chk("nmi_again_inj", {15'd0, inject}, 16'd1);
        last_cycle = 1'b0;
        tick;
        int_ack = 1'b1;
        tick;
        int_ack = 1'b0;
        nmi_b = 1'b1;
        repeat (SL + 1) tick;

        // reset during IRQ service
        irq_b = 1'b0;
        i_flag = 1'b0;
        repeat (SL) tick;
        last_cycle = 1'b1;
        e.vec = 16'hFFFE; e.b = 1'b0; sb.push_back(e);
        tick;
        last_cycle = 1'b0;
        nmi_b = 1'b0;
        repeat (SL + 1) tick;
        chk("mid_svc_vec", vec_addr, 16'hFFFE);
        chk("mid_pend", {15'd0, dut.nmi_pend_q}, 16'd1);
        #1;
        reset = 1'b1;
        #1;
        chk("arst_vec", vec_addr, 16'hFFFC);
        chk("arst_inject", {15'd0, inject}, 16'd0);
        chk("arst_busy", {15'd0, busy}, 16'd1);
        chk("arst_bflag", {15'd0, b_flag}, 16'd1);
        chk("arst_pend", {15'd0, dut.nmi_pend_q}, 16'd0);
        tick;
        chk("sb_empty", 16'(sb.size()), 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
